// File: rtl/ad9826_sif_arbiter_pkg.sv
// rtl/ad9826_sif_arbiter_pkg.sv - AD9826 widths, register map and arbiter state encoding
package ad9826_sif_arbiter_pkg;

   localparam int AD9826_DATA_W = 9;
   localparam int AD9826_ADDR_W = 3;

   localparam logic [AD9826_ADDR_W-1:0] AD9826_CONFIG       = 3'd0;
   localparam logic [AD9826_ADDR_W-1:0] AD9826_MUX_CONFIG   = 3'd1;
   localparam logic [AD9826_ADDR_W-1:0] AD9826_RED_PGA      = 3'd2;
   localparam logic [AD9826_ADDR_W-1:0] AD9826_GREEN_PGA    = 3'd3;
   localparam logic [AD9826_ADDR_W-1:0] AD9826_BLUE_PGA     = 3'd4;
   localparam logic [AD9826_ADDR_W-1:0] AD9826_RED_OFFSET   = 3'd5;
   localparam logic [AD9826_ADDR_W-1:0] AD9826_GREEN_OFFSET = 3'd6;
   localparam logic [AD9826_ADDR_W-1:0] AD9826_BLUE_OFFSET  = 3'd7;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/ad9826_rr_pick.sv
// rtl/ad9826_rr_pick.sv - combinational round-robin picker: first request at or after ptr, wrapping
module ad9826_rr_pick
   import ad9826_sif_arbiter_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic [IW:0] pos;

   // Scan positions ptr, ptr+1, ... modulo N and keep the first one requesting
   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = '0;
      for (int i = 0; i < N; i++) begin
         pos = {1'b0, ptr} + (IW+1)'(i);
         if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
         if (!any && req[pos[IW-1:0]]) begin
            any = 1'b1;
            idx = pos[IW-1:0];
         end
      end
      gnt = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/ad9826_sif_arbiter.sv
// rtl/ad9826_sif_arbiter.sv - round-robin arbiter for the AD9826 serial port; AD9826_ARB_TIMEOUT_EN adds a watchdog
module ad9826_sif_arbiter
   import ad9826_sif_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   input  logic [NUM_REQ-1:0]                 req_wr_i,
   input  logic [AD9826_ADDR_W*NUM_REQ-1:0]   req_addr_i,
   input  logic [AD9826_DATA_W*NUM_REQ-1:0]   req_wdata_i,
   output logic [NUM_REQ-1:0]                 req_ack_o,
   output logic [NUM_REQ-1:0]                 rsp_valid_o,
   output logic [AD9826_DATA_W-1:0]           rsp_rdata_o,
   output logic                               rsp_err_o,
   output logic                               sif_wr_o,
   output logic                               sif_rd_o,
   output logic [AD9826_ADDR_W-1:0]           sif_addr_o,
   output logic [AD9826_DATA_W-1:0]           sif_wdata_o,
   input  logic                               sif_ready_i,
   input  logic                               sif_done_i,
   input  logic [AD9826_DATA_W-1:0]           sif_rdata_i,
   input  logic                               sif_rvalid_i,
   output logic                               busy_o
);

   localparam int IW = $clog2(NUM_REQ);

   arb_state_e                 state_q, state_d;
   logic [IW-1:0]              ptr_q, idx_q;
   logic                       wr_q, err_q;
   logic [AD9826_ADDR_W-1:0]   addr_q;
   logic [AD9826_DATA_W-1:0]   wdata_q, rdata_q;
   logic [NUM_REQ-1:0]         ack_q;

   logic                       pick_any;
   logic [NUM_REQ-1:0]         pick_gnt;
   logic [IW-1:0]              pick_idx;
   logic                       sel_wr;
   logic [AD9826_ADDR_W-1:0]   sel_addr;
   logic [AD9826_DATA_W-1:0]   sel_wdata;
   logic                       grant, complete, timeout;

   ad9826_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req (req_valid_i),
      .ptr (ptr_q),
      .any (pick_any),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // Route the winning requester's fields to the capture registers
   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_gnt[k]) begin
            sel_wr    = req_wr_i[k];
            sel_addr  = req_addr_i[k*AD9826_ADDR_W +: AD9826_ADDR_W];
            sel_wdata = req_wdata_i[k*AD9826_DATA_W +: AD9826_DATA_W];
         end
      end
   end

`ifdef AD9826_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC) + 1;
   logic [CW-1:0] tmo_cnt_q;

   // Watchdog restarts at each grant and runs while the transaction is outstanding
   always_ff @(posedge clk) begin
      if (rst)
         tmo_cnt_q <= '0;
      else if (grant)
         tmo_cnt_q <= '0;
      else if (state_q == ARB_ISSUE || state_q == ARB_WAIT)
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end

   assign timeout = (state_q == ARB_ISSUE || state_q == ARB_WAIT) &&
                    (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ARB_IDLE;
      else     state_q <= state_d;
   end

   // Next state and strobes; a timeout in ISSUE suppresses the strobe, a completion in WAIT beats a timeout
   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      complete    = 1'b0;
      sif_wr_o    = 1'b0;
      sif_rd_o    = 1'b0;
      rsp_valid_o = '0;
      busy_o      = (state_q != ARB_IDLE);
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               grant   = 1'b1;
               state_d = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            if (timeout) begin
               state_d = ARB_RESP;
            end else if (sif_ready_i) begin
               sif_wr_o = wr_q;
               sif_rd_o = ~wr_q;
               state_d  = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (wr_q ? sif_done_i : sif_rvalid_i) begin
               complete = 1'b1;
               state_d  = ARB_RESP;
            end else if (timeout) begin
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            rsp_valid_o = NUM_REQ'(1) << idx_q;
            state_d     = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Capture the granted request, latch the result, and advance the fairness pointer past the served requester
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ack_q   <= '0;
      end else begin
         ack_q <= grant ? pick_gnt : '0;
         if (grant) begin
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            idx_q   <= pick_idx;
            err_q   <= 1'b0;
         end
         if (complete) begin
            rdata_q <= wr_q ? '0 : sif_rdata_i;
            err_q   <= 1'b0;
         end else if (timeout) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
         end
         if (state_q == ARB_RESP)
            ptr_q <= (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   assign req_ack_o   = ack_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign sif_addr_o  = addr_q;
   assign sif_wdata_o = wdata_q;

endmodule

// File: tb/tb_ad9826_sif_arbiter.sv
// tb/tb_ad9826_sif_arbiter.sv - directed bench for ad9826_sif_arbiter with a serial_interface model
module tb_ad9826_sif_arbiter;
   import ad9826_sif_arbiter_pkg::*;

   localparam int N    = 3;
   localparam int TCYC = 16;
`ifdef AD9826_ARB_TIMEOUT_EN
   localparam int LONG_DLY = 10;
   localparam int HOLD_CYC = 10;
`else
   localparam int LONG_DLY = 20;
   localparam int HOLD_CYC = 50;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req_valid_i = '0, req_wr_i = '0;
   logic [3*N-1:0] req_addr_i = '0;
   logic [9*N-1:0] req_wdata_i = '0;
   logic [N-1:0] req_ack_o, rsp_valid_o;
   logic [8:0]   rsp_rdata_o;
   logic         rsp_err_o, sif_wr_o, sif_rd_o, busy_o;
   logic [2:0]   sif_addr_o;
   logic [8:0]   sif_wdata_o;
   logic         sif_ready_i = 1'b1;
   logic         sif_done_i, sif_rvalid_i;
   logic [8:0]   sif_rdata_i;

   ad9826_sif_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TCYC)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .req_ack_o(req_ack_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .sif_wr_o(sif_wr_o), .sif_rd_o(sif_rd_o), .sif_addr_o(sif_addr_o), .sif_wdata_o(sif_wdata_o),
      .sif_ready_i(sif_ready_i), .sif_done_i(sif_done_i), .sif_rdata_i(sif_rdata_i),
      .sif_rvalid_i(sif_rvalid_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({req_ack_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, sif_wr_o, sif_rd_o,
                  sif_addr_o, sif_wdata_o, busy_o});
   endfunction

   // serial_interface model: counts strobes, answers after model_delay cycles
   int         model_delay = 1;
   logic [8:0] model_rdata = '0;
   bit         model_mute  = 1'b0;
   bit         model_noise = 1'b0;
   int         n_strobe = 0;
   int         resp_at  = 0;
   logic [2:0] last_addr  = '0;
   logic [8:0] last_wdata = '0;
   bit         last_wr = 1'b0;
   bit         pend = 1'b0;
   bit         pend_wr = 1'b0;
   int         left = 0;

   initial begin
      sif_done_i = 1'b0; sif_rvalid_i = 1'b0; sif_rdata_i = '0;
      forever begin
         @(negedge clk); #1;
         sif_done_i = 1'b0; sif_rvalid_i = 1'b0;
         if (rst) begin
            pend = 1'b0;
         end else if (sif_wr_o || sif_rd_o) begin
            n_strobe++;
            last_addr = sif_addr_o; last_wdata = sif_wdata_o; last_wr = sif_wr_o;
            pend = 1'b1; pend_wr = sif_wr_o; left = model_delay;
         end else if (pend && !model_mute) begin
            if (left <= 1) begin
               sif_rdata_i = model_rdata;
               if (pend_wr) sif_done_i = 1'b1; else sif_rvalid_i = 1'b1;
               pend = 1'b0;
               resp_at = cyc;
            end else begin
               if (model_noise && left == 2) begin
                  if (pend_wr) sif_rvalid_i = 1'b1; else sif_done_i = 1'b1;
               end
               left--;
            end
         end
      end
   end

   typedef struct {
      int         k;
      bit         wr;
      logic [2:0] addr;
      logic [8:0] wdata;
      logic [8:0] mrd;
      int         dly;
      bit         noise;
      logic [8:0] exp_rd;
   } vec_t;

   vec_t vecs [6];

   task automatic wait_ack(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (req_ack_o == '0 && n < 20);
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (rsp_valid_o == '0 && n < 200) begin @(negedge clk); n++; end
   endtask

   task automatic run_vec(input vec_t v);
      int n, s0;
      logic [N-1:0] oh;
      oh = 3'(1) << v.k;
      @(negedge clk);
      req_wr_i[v.k] = v.wr;
      req_addr_i[3*v.k +: 3] = v.addr;
      req_wdata_i[9*v.k +: 9] = v.wdata;
      model_delay = v.dly; model_rdata = v.mrd; model_noise = v.noise;
      s0 = n_strobe;
      req_valid_i[v.k] = 1'b1;
      wait_ack(n);
      chk("ack_latency", n, 1);
      chk("ack_vector", 32'(req_ack_o), 32'(oh));
      req_valid_i[v.k] = 1'b0;
      wait_rsp(n);
      chk("rsp_vector", 32'(rsp_valid_o), 32'(oh));
      chk("rsp_rdata", 32'(rsp_rdata_o), 32'(v.exp_rd));
      chk("rsp_err", 32'(rsp_err_o), 0);
      chk("rsp_after_model", cyc - resp_at, 1);
      chk("strobe_count", n_strobe - s0, 1);
      chk("strobe_kind", 32'(last_wr), 32'(v.wr));
      chk("strobe_addr", 32'(last_addr), 32'(v.addr));
      if (v.wr) chk("strobe_wdata", 32'(last_wdata), 32'(v.wdata));
      @(negedge clk);
      chk("rsp_one_cycle", 32'(rsp_valid_o), 0);
      chk("rdata_hold", 32'(rsp_rdata_o), 32'(v.exp_rd));
      model_noise = 1'b0;
   endtask

   initial begin
      int n, s0, a;
      bit saw;
      vecs[0] = '{0, 1'b1, AD9826_CONFIG,       9'h0C8, 9'h000, LONG_DLY, 1'b0, 9'h000};
      vecs[1] = '{1, 1'b0, AD9826_MUX_CONFIG,   9'h000, 9'h0C0, 5,        1'b1, 9'h0C0};
      vecs[2] = '{2, 1'b1, AD9826_BLUE_OFFSET,  9'h1FF, 9'h055, 3,        1'b1, 9'h000};
      vecs[3] = '{2, 1'b0, AD9826_RED_OFFSET,   9'h000, 9'h155, 1,        1'b0, 9'h155};
      vecs[4] = '{0, 1'b1, AD9826_GREEN_OFFSET, 9'h0AA, 9'h0F0, 2,        1'b0, 9'h000};
      vecs[5] = '{1, 1'b0, AD9826_RED_PGA,      9'h000, 9'h1AB, 2,        1'b0, 9'h1AB};

      repeat (3) @(negedge clk);
      chk("reset_outputs", all_outs(), 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset while waiting for a read that never completes
      model_mute = 1'b1;
      @(negedge clk);
      req_wr_i[1] = 1'b0; req_addr_i[5:3] = AD9826_GREEN_PGA;
      req_valid_i[1] = 1'b1;
      wait_ack(n);
      req_valid_i[1] = 1'b0;
      @(negedge clk);
      chk("wait_busy", 32'(busy_o), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_in_wait", all_outs(), 0);
      rst = 1'b0;
      model_mute = 1'b0;
      saw = 1'b0;
      repeat (4) begin @(negedge clk); if (rsp_valid_o != '0 || busy_o) saw = 1'b1; end
      chk("no_rsp_after_reset", 32'(saw), 0);

      // All three requesters held: pointer restarts at 0 and rotates
      model_delay = 2;
      s0 = n_strobe;
      for (int k = 0; k < N; k++) begin
         req_wr_i[k] = 1'b1;
         req_addr_i[3*k +: 3] = 3'(k + 2);
         req_wdata_i[9*k +: 9] = 9'(k + 9'h010);
      end
      req_valid_i = '1;
      for (int g = 0; g < 6; g++) begin
         wait_ack(n);
         chk("rr_ack", 32'(req_ack_o), 32'(3'(1) << (g % 3)));
         wait_rsp(n);
         chk("rr_rsp", 32'(rsp_valid_o), 32'(3'(1) << (g % 3)));
         chk("rr_addr", 32'(last_addr), 32'((g % 3) + 2));
         chk("rr_strobes", n_strobe - s0, g + 1);
         if (g == 5) req_valid_i = '0;
      end
      repeat (3) @(negedge clk);
      chk("idle_after_rr", 32'(busy_o), 0);

      // serial_interface not ready: no strobe until ready rises
      sif_ready_i = 1'b0;
      model_delay = 1; model_rdata = 9'h03C;
      s0 = n_strobe;
      req_wr_i[2] = 1'b0; req_addr_i[8:6] = AD9826_BLUE_PGA;
      req_valid_i[2] = 1'b1;
      wait_ack(n);
      req_valid_i[2] = 1'b0;
      repeat (HOLD_CYC) @(negedge clk);
      chk("hold_no_strobe", n_strobe - s0, 0);
      chk("hold_busy", 32'(busy_o), 1);
      sif_ready_i = 1'b1;
      wait_rsp(n);
      chk("hold_rsp", 32'(rsp_valid_o), 32'(3'b100));
      chk("hold_rdata", 32'(rsp_rdata_o), 32'h03C);
      chk("hold_one_strobe", n_strobe - s0, 1);

`ifdef AD9826_ARB_TIMEOUT_EN
      // Model never answers: watchdog ends the transaction with an error
      model_mute = 1'b1;
      @(negedge clk);
      req_wr_i[0] = 1'b1; req_addr_i[2:0] = AD9826_CONFIG;
      req_valid_i[0] = 1'b1;
      wait_ack(n);
      a = cyc;
      req_valid_i[0] = 1'b0;
      wait_rsp(n);
      chk("tmo_latency", cyc - a, TCYC);
      chk("tmo_rsp", 32'(rsp_valid_o), 32'(3'b001));
      chk("tmo_err", 32'(rsp_err_o), 1);
      chk("tmo_rdata", 32'(rsp_rdata_o), 32'h1FF);
`else
      a = 0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
